feed_pop_scheduler: RTL and testbench



---
 rtl/feed_pop_scheduler.sv | 152 +++++++++++++++
 tb/tb_feed_pop_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_pop_scheduler.sv
// feed_pop_scheduler: issues diagonally skewed pop enables to a row of feeder
// lanes. It owns the shared FIFO clear and the array pipeline enable, and holds
// the array whenever a lane that is due to pop has an empty FIFO.
// Optional: define FEED_SCHED_STALL_CNT_EN to count underrun stall cycles on
// o_stall_cnt; otherwise o_stall_cnt is tied to zero.
module feed_pop_scheduler #(
    parameter int unsigned N_LANES     = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [CNT_W-1:0]       i_tile_len,
    input  logic                   i_sa_en,
    input  logic [N_LANES-1:0]     i_lane_empty,
    input  logic [N_LANES-1:0]     i_lane_full,
    output logic [N_LANES-1:0]     o_pop_en,
    output logic                   o_pipeline_en,
    output logic                   o_clearfifo,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [N_LANES-1:0] sr;
    logic [N_LANES-1:0] sr_adv;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   pop_cnt;
    logic               sr_active;
    logic               underrun;
    logic               last_pop;
    logic               head;
    logic               lane_full_unused;

    // Only lane 0's full flag gates the start of a tile.
    assign lane_full_unused = ^i_lane_full;

    assign o_pop_en = sr;

    // Stall detection, pipeline enable and next skew-register value.
    always_comb begin
        sr_active     = (state == S_RUN) || (state == S_DRAIN);
        underrun      = sr_active && (|(sr & i_lane_empty));
        o_pipeline_en = (sr_active || (state == S_FILL)) && i_sa_en && !underrun;
        last_pop      = (pop_cnt == (len_q - CNT_W'(1)));
        head          = (state == S_RUN) && !last_pop;
        sr_adv        = N_LANES'({sr, head});
        o_busy        = (state != S_IDLE);
    end

    // Tile sequencing FSM with registered pop/clear/done outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_IDLE;
            sr          <= '0;
            len_q       <= '0;
            pop_cnt     <= '0;
            o_clearfifo <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_clearfifo <= 1'b0;
            o_done      <= 1'b0;
            if (i_abort && (state != S_IDLE)) begin
                state       <= S_IDLE;
                sr          <= '0;
                pop_cnt     <= '0;
                o_clearfifo <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            len_q       <= i_tile_len;
                            pop_cnt     <= '0;
                            o_clearfifo <= 1'b1;
                            state       <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        if (len_q != '0) begin
                            state <= S_FILL;
                        end else begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (!i_lane_empty[0] || i_lane_full[0]) begin
                            sr    <= N_LANES'(1);
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        // The head bit drops on the advance that issues lane 0's last pop.
                        if (o_pipeline_en) begin
                            sr      <= sr_adv;
                            pop_cnt <= pop_cnt + CNT_W'(1);
                            if (last_pop) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (sr == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else if (o_pipeline_en) begin
                            sr <= sr_adv;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FEED_SCHED_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating underrun stall counter, cleared on each accepted start.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && i_start) begin
            stall_q <= '0;
        end else if (underrun && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_feed_pop_scheduler.sv
// Testbench for feed_pop_scheduler: directed scenarios plus random stimulus,
// compared cycle by cycle against a tile-level reference model.
module tb_feed_pop_scheduler;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] tlen = '0;
    logic          sa = 1'b1;
    logic [N-1:0]  empty = '0;
    logic [N-1:0]  full = '0;
    logic [N-1:0]  o_pop_en;
    logic          o_pipeline_en;
    logic          o_clearfifo;
    logic          o_busy;
    logic          o_done;
    logic [SW-1:0] o_stall_cnt;

    always #5 clk = ~clk;

    feed_pop_scheduler #(
        .N_LANES     (N),
        .CNT_W       (CW),
        .STALL_CNT_W (SW)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_start       (start),
        .i_abort       (abort),
        .i_tile_len    (tlen),
        .i_sa_en       (sa),
        .i_lane_empty  (empty),
        .i_lane_full   (full),
        .o_pop_en      (o_pop_en),
        .o_pipeline_en (o_pipeline_en),
        .o_clearfifo   (o_clearfifo),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_stall_cnt   (o_stall_cnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 clear, 2 fill, 3 active, 4 done.
    // 'a' counts advancing cycles since the first pop; lane k pops while k <= a < k+len.
    int       ph = 0;
    int       a = 0;
    int       mlen = 0;
    int       mstall = 0;
    bit       mclr = 1'b0;
    bit       exp_pe;
    logic [N-1:0] exp_pop;
    int       dut_pops[N];
    int       cyc = 0;
    int       done_cyc = 0;
    int       done_seen = 0;
    int       start_cyc = 0;

    logic          d_start = 1'b0;
    logic          d_abort = 1'b0;
    logic [CW-1:0] d_len = '0;
    logic          d_sa = 1'b1;
    logic [N-1:0]  d_empty = '0;
    logic [N-1:0]  d_full = '0;

    task automatic step();
        bit under;
        @(negedge clk);
        start = d_start;
        abort = d_abort;
        tlen  = d_len;
        sa    = d_sa;
        empty = d_empty;
        full  = d_full;
        #1;
        exp_pop = '0;
        for (int k = 0; k < N; k++)
            if (ph == 3 && a >= k && a < k + mlen) exp_pop[k] = 1'b1;
        under  = (exp_pop & empty) != '0;
        exp_pe = (ph == 2 || ph == 3) && sa && !under;
        chk("pop_en", o_pop_en, exp_pop);
        chk("pipeline_en", o_pipeline_en, exp_pe);
        chk("clearfifo", o_clearfifo, mclr);
        chk("busy", o_busy, ph != 0);
        chk("done", o_done, ph == 4);
        chk("stall_cnt", o_stall_cnt, mstall);
        for (int k = 0; k < N; k++)
            if (o_pop_en[k] && o_pipeline_en) dut_pops[k]++;
        if (o_done) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (ph == 4)
            for (int k = 0; k < N; k++) chk("pops_per_lane", dut_pops[k], mlen);
        @(posedge clk);
        if (rstn) begin
`ifdef FEED_SCHED_STALL_CNT_EN
            if (ph == 3 && under && mstall < (1 << SW) - 1) mstall++;
`endif
            mclr = 1'b0;
            if (abort && ph != 0) begin
                ph = 0;
                a = 0;
                mclr = 1'b1;
            end else begin
                case (ph)
                    0: if (start) begin
                        mlen = int'(tlen);
                        ph = 1;
                        mclr = 1'b1;
                        mstall = 0;
                        for (int k = 0; k < N; k++) dut_pops[k] = 0;
                    end
                    1: ph = (mlen != 0) ? 2 : 4;
                    2: if (!empty[0] || full[0]) begin
                        ph = 3;
                        a = 0;
                    end
                    3: if (a == mlen + N - 1) ph = 4;
                       else if (exp_pe) a++;
                    default: ph = 0;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("rst_pop_en", o_pop_en, 0);
        chk("rst_pipeline_en", o_pipeline_en, 0);
        chk("rst_clearfifo", o_clearfifo, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_stall_cnt", o_stall_cnt, 0);
        ph = 0;
        a = 0;
        mclr = 1'b0;
        mstall = 0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic idle_inputs();
        d_start = 1'b0;
        d_abort = 1'b0;
        d_sa    = 1'b1;
        d_empty = '0;
        d_full  = '0;
    endtask

    task automatic start_tile(input int len);
        d_start = 1'b1;
        d_len   = CW'(len);
        start_cyc = cyc;
        step();
        d_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit fin = 1'b0;
        for (int i = 0; i < max_cyc && !fin; i++) begin
            step();
            if (ph == 0) fin = 1'b1;
        end
        chk("tile_finish", fin, 1);
    endtask

    task automatic wait_adv(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && !(ph == 3 && a == target); i++) step();
        chk("reach_run", (ph == 3 && a == target), 1);
    endtask

    int base;

    initial begin
        for (int k = 0; k < N; k++) dut_pops[k] = 0;
        do_reset();
        idle_inputs();
        step();

        // basic tile, len=5
        base = done_seen;
        start_tile(5);
        wait_done(40);
        chk("len5_latency", done_cyc - start_cyc, 12);
        chk("len5_done_count", done_seen - base, 1);

        // zero-length tile
        start_tile(0);
        wait_done(10);
        chk("len0_latency", done_cyc - start_cyc, 2);

        // lane 2 underrun for 3 cycles
        start_tile(6);
        wait_adv(3, 20);
        d_empty = 4'b0100;
        repeat (3) step();
        d_empty = '0;
        wait_done(40);
        chk("underrun_latency", done_cyc - start_cyc, 16);
`ifdef FEED_SCHED_STALL_CNT_EN
        chk("underrun_stall_total", o_stall_cnt, 3);
`else
        chk("underrun_stall_total", o_stall_cnt, 0);
`endif

        // downstream hold for 4 cycles mid-run
        start_tile(5);
        wait_adv(2, 20);
        d_sa = 1'b0;
        repeat (4) step();
        d_sa = 1'b1;
        wait_done(40);
        chk("sa_hold_latency", done_cyc - start_cyc, 16);

        // abort during drain, then a normal tile
        base = done_seen;
        start_tile(4);
        wait_adv(5, 30);
        d_abort = 1'b1;
        step();
        d_abort = 1'b0;
        step();
        chk("abort_clearfifo", o_clearfifo, 1);
        chk("abort_idle", o_busy, 0);
        repeat (3) step();
        chk("abort_no_done", done_seen - base, 0);
        start_tile(2);
        wait_done(30);
        chk("after_abort_latency", done_cyc - start_cyc, 9);

        // start while busy is ignored
        start_tile(3);
        repeat (2) step();
        d_start = 1'b1;
        d_len = CW'(9);
        step();
        d_start = 1'b0;
        wait_done(40);
        chk("busy_start_latency", done_cyc - start_cyc, 10);

        // asynchronous reset mid-run
        start_tile(6);
        wait_adv(2, 20);
        do_reset();
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            d_start = ($urandom_range(0, 5) == 0);
            d_abort = ($urandom_range(0, 59) == 0);
            d_len   = CW'($urandom_range(0, 7));
            d_sa    = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < N; k++) begin
                d_empty[k] = ($urandom_range(0, 7) == 0);
                d_full[k]  = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 1499) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
